// File: rtl/text_pixel_pipe.sv
// Text-mode pixel pipeline: 8x16 character cells, fetched through synchronous char RAM
// and font ROM. The colour index and the delayed syncs come out exactly 3 clocks after their inputs.
module text_pixel_pipe #(
    parameter int unsigned COLS    = 100,
    parameter int unsigned ROWS    = 37,
    parameter int unsigned CADDR_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        hcount,
    input  logic [15:0]        vcount,
    input  logic               hvis,
    input  logic               vvis,
    input  logic               hsync,
    input  logic               vsync,
    output logic [CADDR_W-1:0] char_addr,
    input  logic [15:0]        char_data,
    output logic [11:0]        font_addr,
    input  logic [7:0]         font_data,
    output logic [3:0]         pix_color,
    output logic               pix_vis,
    output logic               pix_hsync,
    output logic               pix_vsync
);

    logic [15:0] addr_full_s;
    logic        row_ok_s;

    logic [2:0]  s1_hsub_r;
    logic [3:0]  s1_vsub_r;
    logic        s1_row_ok_r;
    logic        s1_vis_r;
    logic        s1_hsync_r;
    logic        s1_vsync_r;

    logic [2:0]  s2_hsub_r;
    logic [7:0]  s2_attr_r;
    logic        s2_row_ok_r;
    logic        s2_vis_r;
    logic        s2_hsync_r;
    logic        s2_vsync_r;

    logic        vsync_q_r;
    logic [5:0]  frame_cnt_r;

    logic        font_bit_s;
    logic [3:0]  fg_eff_s;
    logic [3:0]  color_s;

    // S0: cell address and row range check from the incoming coordinates
    always_comb begin
        addr_full_s = 16'(vcount[9:4]) * 16'(COLS) + 16'(hcount[9:3]);
        char_addr   = addr_full_s[CADDR_W-1:0];
        row_ok_s    = (32'(vcount[9:4]) < ROWS);
    end

    // S1: glyph row address from the character code returned by the RAM
    always_comb begin
        font_addr = {char_data[7:0], s1_vsub_r};
    end

    // Pipeline stage registers S0->S1->S2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hsub_r   <= 3'd0;
            s1_vsub_r   <= 4'd0;
            s1_row_ok_r <= 1'b0;
            s1_vis_r    <= 1'b0;
            s1_hsync_r  <= 1'b0;
            s1_vsync_r  <= 1'b0;
            s2_hsub_r   <= 3'd0;
            s2_attr_r   <= 8'd0;
            s2_row_ok_r <= 1'b0;
            s2_vis_r    <= 1'b0;
            s2_hsync_r  <= 1'b0;
            s2_vsync_r  <= 1'b0;
        end else begin
            s1_hsub_r   <= hcount[2:0];
            s1_vsub_r   <= vcount[3:0];
            s1_row_ok_r <= row_ok_s;
            s1_vis_r    <= hvis & vvis;
            s1_hsync_r  <= hsync;
            s1_vsync_r  <= vsync;
            s2_hsub_r   <= s1_hsub_r;
            s2_attr_r   <= char_data[15:8];
            s2_row_ok_r <= s1_row_ok_r;
            s2_vis_r    <= s1_vis_r;
            s2_hsync_r  <= s1_hsync_r;
            s2_vsync_r  <= s1_vsync_r;
        end
    end

    // Frame counter advanced on each vsync rising edge; bit 5 drives the blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q_r   <= 1'b0;
            frame_cnt_r <= 6'd0;
        end else begin
            vsync_q_r <= vsync;
            if (vsync && !vsync_q_r) begin
                frame_cnt_r <= frame_cnt_r + 6'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // S2: pick the glyph bit and resolve blink and blanking into a colour index
    always_comb begin
        font_bit_s = font_data[3'd7 - s2_hsub_r];
        if (s2_attr_r[7] && frame_cnt_r[5]) begin
            fg_eff_s = {1'b0, s2_attr_r[6:4]};
        end else begin
            fg_eff_s = s2_attr_r[3:0];
        end
        if (!s2_vis_r || !s2_row_ok_r) begin
            color_s = 4'd0;
        end else if (font_bit_s) begin
            color_s = fg_eff_s;
        end else begin
            color_s = {1'b0, s2_attr_r[6:4]};
        end
    end

    // Output registers toward the palette/DAC stage
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_color <= 4'd0;
            pix_vis   <= 1'b0;
            pix_hsync <= 1'b0;
            pix_vsync <= 1'b0;
        end else begin
            pix_color <= color_s;
            pix_vis   <= s2_vis_r;
            pix_hsync <= s2_hsync_r;
            pix_vsync <= s2_vsync_r;
        end
    end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Bench for text_pixel_pipe: synchronous RAM/ROM models, a vector table and blink sequences,
// with expected outputs queued at drive time and compared 3 cycles later.
module tb_text_pixel_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] hcount = 16'd0;
    logic [15:0] vcount = 16'd0;
    logic        hvis = 1'b0;
    logic        vvis = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [12:0] char_addr;
    logic [15:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  pix_color;
    logic        pix_vis;
    logic        pix_hsync;
    logic        pix_vsync;

    text_pixel_pipe dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hvis(hvis), .vvis(vvis), .hsync(hsync), .vsync(vsync),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
        .pix_color(pix_color), .pix_vis(pix_vis),
        .pix_hsync(pix_hsync), .pix_vsync(pix_vsync)
    );

    always #5 clk = ~clk;

    logic [15:0] char_mem [0:8191];
    logic [7:0]  font_mem [0:4095];

    // Synchronous-read memories: data for this cycle's address arrives next cycle
    always @(posedge clk) begin
        char_data <= char_mem[char_addr];
        font_data <= font_mem[font_addr];
    end

    typedef struct {
        logic [3:0] col;
        logic       vis;
        logic       hs;
        logic       vs;
        string      tag;
    } exp_t;

    typedef struct {
        logic [15:0] h;
        logic [15:0] v;
        logic        hv;
        logic        vv;
        logic        hs;
        logic        vs;
        logic [3:0]  col;
        string       tag;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[11];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [12:0] drv_char_addr;
    logic [11:0] smp_font_addr;
    logic [11:0] want_font_addr;

    task automatic cycle(input logic [15:0] h, input logic [15:0] v, input logic hv,
                         input logic vv, input logic hs, input logic vs,
                         input logic [3:0] col, input string tag);
        exp_t e;
        @(negedge clk);
        if (sbq.size() == 3) begin
            e = sbq.pop_front();
            n_tests++;
            if ({pix_color, pix_vis, pix_hsync, pix_vsync} !== {e.col, e.vis, e.hs, e.vs}) begin
                n_fail++;
                $display("FAIL %s: got col=%h vis=%b hs=%b vs=%b, want col=%h vis=%b hs=%b vs=%b",
                         e.tag, pix_color, pix_vis, pix_hsync, pix_vsync, e.col, e.vis, e.hs, e.vs);
            end
        end
        smp_font_addr = font_addr;
        rst    = 1'b0;
        hcount = h;
        vcount = v;
        hvis   = hv;
        vvis   = vv;
        hsync  = hs;
        vsync  = vs;
        #1;
        drv_char_addr = char_addr;
        e.col = col;
        e.vis = hv & vv;
        e.hs  = hs;
        e.vs  = vs;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "idle");
    endtask

    task automatic vs_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "vs_pulse_hi");
            cycle(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "vs_pulse_lo");
        end
    endtask

    task automatic do_reset();
        exp_t z;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_tests++;
                if ({pix_color, pix_vis, pix_hsync, pix_vsync} !== 7'd0) begin
                    n_fail++;
                    $display("FAIL reset_hold: got col=%h vis=%b hs=%b vs=%b, want all 0",
                             pix_color, pix_vis, pix_hsync, pix_vsync);
                end
            end
            hcount = 16'd16;
            vcount = 16'd35;
            hvis   = i[0];
            vvis   = 1'b1;
            hsync  = ~i[0];
            vsync  = i[0];
        end
        n_tests++;
        if (dut.frame_cnt_r !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_frame_cnt: got %0d, want 0", dut.frame_cnt_r);
        end
        sbq.delete();
        z.col = 4'h0; z.vis = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.tag = "post_reset_flush";
        sbq.push_back(z);
        sbq.push_back(z);
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) char_mem[a] = 16'h0000;
        for (int a = 0; a < 4096; a++) font_mem[a] = 8'h00;
        char_mem[202]  = 16'h2A41;
        char_mem[510]  = 16'h2F42;
        char_mem[3600] = 16'h2F42;
        char_mem[3700] = 16'h2F42;
        char_mem[100]  = 16'hAF43;
        char_mem[101]  = 16'h2F42;
        font_mem[{8'h41, 4'd3}] = 8'b1000_0001;
        for (int r = 0; r < 16; r++) begin
            font_mem[{8'h42, 4'(r)}] = 8'hFF;
            font_mem[{8'h43, 4'(r)}] = 8'hFF;
        end

        vecs[0]  = '{16'd16, 16'd35,  1'b1, 1'b1, 1'b0, 1'b0, 4'hA, "pixsel_bit7"};
        vecs[1]  = '{16'd23, 16'd35,  1'b1, 1'b1, 1'b0, 1'b0, 4'hA, "pixsel_bit0"};
        vecs[2]  = '{16'd19, 16'd35,  1'b1, 1'b1, 1'b0, 1'b0, 4'h2, "pixsel_bg"};
        vecs[3]  = '{16'd80, 16'd80,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, "blank_hvis"};
        vecs[4]  = '{16'd80, 16'd80,  1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "fg_full"};
        vecs[5]  = '{16'd81, 16'd85,  1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "fg_row5"};
        vecs[6]  = '{16'd0,  16'd592, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, "row37_blank"};
        vecs[7]  = '{16'd0,  16'd576, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "row36_last"};
        vecs[8]  = '{16'd87, 16'd95,  1'b1, 1'b0, 1'b0, 1'b0, 4'h0, "blank_vvis"};
        vecs[9]  = '{16'd16, 16'd35,  1'b1, 1'b1, 1'b1, 1'b0, 4'hA, "hsync_align"};
        vecs[10] = '{16'd19, 16'd35,  1'b1, 1'b1, 1'b0, 1'b1, 4'h2, "vsync_align"};

        do_reset();

        // Addressing: cell (row 2, col 2) and its glyph row address one cycle later
        cycle(16'd17, 16'd35, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, "addr_pixel");
        n_tests++;
        if (drv_char_addr !== 13'd202) begin
            n_fail++;
            $display("FAIL char_addr: got %0d, want 202", drv_char_addr);
        end
        idle(1);
        want_font_addr = {8'h41, 4'd3};
        n_tests++;
        if (smp_font_addr !== want_font_addr) begin
            n_fail++;
            $display("FAIL font_addr: got %h, want %h", smp_font_addr, want_font_addr);
        end
        idle(3);

        // Isolated sync/visible pulse: scoreboard pins the rise and fall to 3 cycles
        idle(6);
        cycle(16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, "sync_vis_pulse");
        idle(4);

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].h, vecs[i].v, vecs[i].hv, vecs[i].vv, vecs[i].hs, vecs[i].vs,
                  vecs[i].col, vecs[i].tag);
        end
        idle(4);

        // Blink: fresh counter, then 32 edges to flip the phase, then 32 more to wrap
        do_reset();
        cycle(16'd0, 16'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "blink_phase0");
        cycle(16'd8, 16'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "noblink_phase0");
        idle(3);
        vs_pulses(32);
        cycle(16'd0, 16'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, "blink_phase1");
        cycle(16'd8, 16'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "noblink_phase1");
        idle(3);
        vs_pulses(32);
        cycle(16'd0, 16'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "blink_wrap");
        cycle(16'd8, 16'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, "noblink_wrap");
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
